systolic_result_drain: RTL

//  Consumer end of the systolic array result interface. Captures the 512-bit

---
 rtl/systolic_result_drain_pkg.sv | 17 +
 rtl/systolic_result_drain_if.sv | 35 +++
 rtl/systolic_result_drain_buf.sv | 29 ++
 rtl/systolic_result_drain.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared constants and FSM state type for the systolic result drain.
// Row/column indices are slices of the word index, so SYS_N must be a power of two.
package systolic_pkg;

    localparam int SYS_N     = 4;
    localparam int SYS_ACC_W = 32;
    localparam int SYS_WORDS = SYS_N * SYS_N;
    localparam int SYS_RC_W  = $clog2(SYS_N);
    localparam int SYS_IDX_W = 2 * SYS_RC_W;
    localparam int SYS_Y_W   = SYS_WORDS * SYS_ACC_W;

    typedef enum logic {
        DR_IDLE,
        DR_STREAM
    } drain_state_t;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Word stream from the result drain to the host.
// Master drives data, valid, last and indices. Slave drives ready.
interface systolic_result_drain_if
    import systolic_pkg::*;
#(
    parameter int ACC_W = SYS_ACC_W,
    parameter int RC_W  = SYS_RC_W
);

    logic signed [ACC_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic        [RC_W-1:0]  out_row;
    logic        [RC_W-1:0]  out_col;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_row,
        input  out_col,
        output out_ready
    );

endinterface

// File: rtl/systolic_result_drain_buf.sv
// result_word_buf: one captured N*N-word result frame with a word-select mux.
// Word 0 (C[0][0]) lives in the most significant slice, matching the array's y bus.
module result_word_buf
    import systolic_pkg::*;
#(
    parameter int N     = SYS_N,
    parameter int ACC_W = SYS_ACC_W
) (
    input  logic                        clk,
    input  logic                        load,
    input  logic [N*N*ACC_W-1:0]        d,
    input  logic [$clog2(N*N)-1:0]      idx,
    output logic [N*N*ACC_W-1:0]        q,
    output logic [ACC_W-1:0]            word
);

    localparam int WORDS = N * N;

    // NOTE: the data store has no reset; its contents only matter while a valid flag
    // (kept in the parent) says so, and leaving it unreset keeps it plain flops.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

    assign word = q[(WORDS - 1 - int'(idx)) * ACC_W +: ACC_W];

endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures y on a done_matrix_mult rising edge, streams it row-major.
// Define SYS_DRAIN_DBUF_EN to add a pending frame buffer that absorbs one early capture.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N     = SYS_N,
    parameter int ACC_W = SYS_ACC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done_matrix_mult,
    input  logic [N*N*ACC_W-1:0]   y,
    systolic_result_drain_if.master stream,
    output logic                   busy,
    output logic                   overrun_err,
    input  logic                   err_clr
);

    localparam int WORDS = N * N;
    localparam int RC_W  = $clog2(N);
    localparam int IDX_W = 2 * RC_W;
    localparam int Y_W   = WORDS * ACC_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    drain_state_t     state;
    logic             done_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] idx;

    logic             cap;
    logic             accept;
    logic             final_acc;
    logic             load_active;
    logic             load_pending;
    logic             cap_lost;
    logic             pending_valid;
    logic [Y_W-1:0]   active_d;
    logic [ACC_W-1:0] active_word;
    logic [Y_W-1:0]   unused_active_q;

    assign cap       = done_matrix_mult && !done_q;
    assign accept    = out_valid_q && stream.out_ready;
    assign final_acc = accept && (idx == LAST_IDX);

    result_word_buf #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_active_buf (
        .clk  (clk),
        .load (load_active),
        .d    (active_d),
        .idx  (idx),
        .q    (unused_active_q),
        .word (active_word)
    );

`ifdef SYS_DRAIN_DBUF_EN
    logic [Y_W-1:0]   pending_q;
    logic [ACC_W-1:0] unused_pending_word;

    result_word_buf #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_pending_buf (
        .clk  (clk),
        .load (load_pending),
        .d    (y),
        .idx  ('0),
        .q    (pending_q),
        .word (unused_pending_word)
    );

    // On the final accept the active buffer frees up: a parked frame moves in and a
    // same-cycle capture takes its place in the pending slot.
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        load_active  = 1'b0;
        load_pending = 1'b0;
        active_d     = y;
        if (state == DR_IDLE) begin
            load_active = cap;
        end else if (final_acc) begin
            if (pending_valid) begin
                load_active  = 1'b1;
                active_d     = pending_q;
                load_pending = cap;
            end else begin
                load_active = cap;
            end
        end else begin
            load_pending = cap && !pending_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_valid <= 1'b0;
        end else if (final_acc && pending_valid) begin
            pending_valid <= cap;
        end else if (load_pending) begin
            pending_valid <= 1'b1;
        end
    end
`else
    assign pending_valid = 1'b0;
    assign load_pending  = 1'b0;
    assign active_d      = y;
    assign load_active   = cap && ((state == DR_IDLE) || final_acc);
`endif

    // A capture while streaming survives only if it lands on the final accept
    // or finds the pending slot free.
    assign cap_lost = cap && (state == DR_STREAM) && !final_acc && !load_pending;

    // done_q resets high so a done level already present at reset release is not an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DR_IDLE;
            done_q      <= 1'b1;
            out_valid_q <= 1'b0;
            idx         <= '0;
            overrun_err <= 1'b0;
        end else begin
            done_q <= done_matrix_mult;

            if (cap_lost) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end

            case (state)
                DR_IDLE: begin
                    if (cap) begin
                        state       <= DR_STREAM;
                        out_valid_q <= 1'b1;
                        idx         <= '0;
                    end
                end
                DR_STREAM: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (!load_active) begin
                                state       <= DR_IDLE;
                                out_valid_q <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= DR_IDLE;
                    out_valid_q <= 1'b0;
                    idx         <= '0;
                end
            endcase
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_valid_q ? active_word : '0;
    assign stream.out_last  = out_valid_q && (idx == LAST_IDX);
    assign stream.out_row   = idx[IDX_W-1:RC_W];
    assign stream.out_col   = idx[RC_W-1:0];

    assign busy = (state == DR_STREAM) || pending_valid;

endmodule
